// File: rtl/pipe_cla_adder.sv
// ============================================================================
//  Module   : pipe_cla_adder
//  Function : Skewed-pipeline carry-lookahead adder/subtractor, one SEG-bit
//             segment per stage, with valid/ready flow control and
//             carry/overflow/zero flags. Optional macro PIPE_CLA_SAT_EN
//             clamps overflowing results to the signed limits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_STAGES = WIDTH / SEG;
    localparam int c_LAST   = c_STAGES - 1;

    generate
        if ((WIDTH % SEG) != 0) begin : g_bad_cfg
            $error("pipe_cla_adder: WIDTH must be a multiple of SEG");
        end
    endgenerate

    // Stage k registers: operands, finished low segments, carry into segment k
    logic [c_STAGES-1:0] r_vld;
    logic [WIDTH-1:0]    r_a [c_STAGES];
    logic [WIDTH-1:0]    r_b [c_STAGES];
    logic [WIDTH-1:0]    r_s [c_STAGES];
    logic [c_STAGES-1:0] r_c;

    logic [SEG+1:0]      w_res   [c_STAGES];
    logic [WIDTH-1:0]    w_snext [c_STAGES];
    logic [WIDTH-1:0]    w_sum;
    logic                w_cout;
    logic                w_ovf;
    logic                w_adv;

    // Returns {carry out, carry into segment MSB, segment sum}; every carry is
    // formed as a sum of generate/propagate products rather than a ripple.
    function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                               input logic [SEG-1:0] y,
                                               input logic           ci);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           prop;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            prop   = 1'b1;
            c[i+1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prop & g[j]);
                prop   = prop & p[j];
            end
            c[i+1] = c[i+1] | (prop & ci);
        end
        return {c[SEG], c[SEG-1], p ^ c[SEG-1:0]};
    endfunction

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        for (int k = 0; k < c_STAGES; k++) begin
            w_res[k]                 = cla_seg(r_a[k][k*SEG +: SEG], r_b[k][k*SEG +: SEG], r_c[k]);
            w_snext[k]               = r_s[k];
            w_snext[k][k*SEG +: SEG] = w_res[k][SEG-1:0];
        end
    end

    always_comb begin
        w_cout = w_res[c_LAST][SEG+1];
        w_ovf  = w_res[c_LAST][SEG+1] ^ w_res[c_LAST][SEG];
`ifdef PIPE_CLA_SAT_EN
        if (w_ovf) begin
            w_sum = r_a[c_LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_sum = w_snext[c_LAST];
        end
`else
        w_sum = w_snext[c_LAST];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld     <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_a[0]   <= a;
            r_b[0]   <= sub ? ~b : b;
            r_c[0]   <= sub | cin;
            r_s[0]   <= '0;
            for (int k = 1; k < c_STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_c[k]   <= w_res[k-1][SEG+1];
                r_s[k]   <= w_snext[k-1];
            end
            out_valid <= r_vld[c_LAST];
            sum       <= w_sum;
            cout      <= w_cout;
            ovf       <= w_ovf;
            zero      <= (w_sum == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
// ============================================================================
//  Module   : tb_pipe_cla_adder
//  Function : Randomized self-checking bench for pipe_cla_adder against an
//             arithmetic reference model and an in-order expectation queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_cla_adder;

    localparam int W  = 32;
    localparam int SG = 8;
    localparam int ST = W / SG;

    localparam logic [W-1:0] VA [8] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5,
                                        32'd7, 32'h8000_0000, 32'h0, 32'd7};
    localparam logic [W-1:0] VB [8] = '{32'h1, 32'h1, 32'h1, 32'd7,
                                        32'd5, 32'h1, 32'h0, 32'd5};
    localparam logic         VC [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic         VS [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    logic         clk = 1'b0;
    logic         reset, in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf, zero;
    logic [W-1:0] a, b, sum;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    res_t exp_q[$];

    pipe_cla_adder #(.WIDTH(W), .SEG(SG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: signed range check for overflow, unsigned compare for borrow.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb);
        res_t         r;
        longint       sx, sy, rs, lim;
        logic [W:0]   wide;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lim = longint'(1) << (W - 1);
        if (sb) begin
            rs  = sx - sy;
            r.s = x - y;
            r.c = (x >= y);
        end else begin
            rs   = sx + sy + longint'(ci);
            wide = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            r.s  = wide[W-1:0];
            r.c  = wide[W];
        end
        r.v = (rs >= lim) || (rs < -lim);
`ifdef PIPE_CLA_SAT_EN
        if (r.v) r.s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        r.z = (r.s == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return $urandom();
        endcase
    endfunction

    task automatic new_ops();
        a   = rand_op();
        b   = rand_op();
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h want 0", sum); end
        total++; if ({cout, ovf, zero} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        reset = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        res_t e;
        int   n;
        for (int i = 0; i < 8; i++) begin
            a = VA[i]; b = VB[i]; cin = VC[i]; sub = VS[i];
            in_valid = 1'b1; out_ready = 1'b1;
            e = model(a, b, cin, sub);
            tick();
            in_valid = 1'b0;
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
            total++; if (n !== ST) begin bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, n, ST); end
            total++; if (sum !== e.s) begin bad++; $display("FAIL dir_sum[%0d]: got %h want %h", i, sum, e.s); end
            total++; if ({cout, ovf, zero} !== {e.c, e.v, e.z})
                begin bad++; $display("FAIL dir_flags[%0d]: got cvz=%b want %b", i, {cout, ovf, zero}, {e.c, e.v, e.z}); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int           issued = 0, got = 0, stall_left = 0, cyc = 0;
        logic         stalled_once = 1'b0, acc;
        logic [W-1:0] held = '0;
        res_t         e;
        exp_q.delete();
        new_ops();
        while ((issued < 6 || got < 6) && cyc < 60) begin
            in_valid = (issued < 6);
            if (out_valid && !stalled_once) begin stalled_once = 1'b1; stall_left = 3; held = sum; end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready: got %b want 0", in_ready); end
                total++; if (sum !== held || out_valid !== 1'b1)
                    begin bad++; $display("FAIL b2b_hold: got sum=%h v=%b want sum=%h v=1", sum, out_valid, held); end
                stall_left--;
            end
            acc = in_valid && in_ready;
            if (acc) begin exp_q.push_back(model(a, b, cin, sub)); issued++; end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: got unexpected result %h want none", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, ovf, zero} !== e)
                        begin bad++; $display("FAIL b2b_result[%0d]: got %h want %h", got, {sum, cout, ovf, zero}, e); end
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) new_ops();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got !== 6 || exp_q.size() != 0 || !stalled_once)
            begin bad++; $display("FAIL b2b_count: got %0d results (%0d pending) want 6 (0)", got, exp_q.size()); end
    endtask

    task automatic test_random();
        logic                 acc, was_stalled;
        logic [W+2:0]         prev;
        res_t                 e;
        exp_q.delete();
        was_stalled = 1'b0;
        prev        = '0;
        new_ops();
        for (int cyc = 0; cyc < 430; cyc++) begin
            if (was_stalled) begin
                total++; if (out_valid !== 1'b1 || {sum, cout, ovf, zero} !== prev)
                    begin bad++; $display("FAIL rnd_stall_hold: got v=%b %h want v=1 %h", out_valid, {sum, cout, ovf, zero}, prev); end
            end
            in_valid  = (cyc < 400) && ($urandom_range(0, 9) < 7);
            out_ready = (cyc >= 400) || ($urandom_range(0, 9) < 7);
            #1;
            total++; if (in_ready !== (!out_valid || out_ready))
                begin bad++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, !out_valid || out_ready); end
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_extra: got unexpected result %h want none", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({sum, cout, ovf, zero} !== e)
                        begin bad++; $display("FAIL rnd_result: got %h want %h", {sum, cout, ovf, zero}, e); end
                end
            end
            was_stalled = out_valid && !out_ready;
            prev        = {sum, cout, ovf, zero};
            @(posedge clk); #1;
            if (acc) new_ops();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        res_t e;
        int   n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            new_ops();
            in_valid = 1'b1;
            reset    = (i == 2);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0;
        total++; if (sum !== '0 || {cout, ovf, zero} !== 3'b000)
            begin bad++; $display("FAIL rst_mid_outputs: got %h cvz=%b want 0 000", sum, {cout, ovf, zero}); end
        for (int i = 0; i < 8; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_flush[%0d]: got %b want 0", i, out_valid); end
            tick();
        end
        new_ops();
        e = model(a, b, cin, sub);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (n !== ST) begin bad++; $display("FAIL rst_mid_latency: got %0d want %0d", n, ST); end
        total++; if ({sum, cout, ovf, zero} !== e)
            begin bad++; $display("FAIL rst_mid_result: got %h want %h", {sum, cout, ovf, zero}, e); end
        tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
